// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, constants and the 16-bit MSB-first priority encode
package pe_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  localparam logic [7:0] NONE_CODE = 8'hF0;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Highest set bit wins; an all-zero input yields NONE_CODE.
  function automatic logic [7:0] pe16(input logic [15:0] v);
    logic [7:0] r;
    r = NONE_CODE;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) r = 8'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_rr_arbiter_if.sv
// rtl/pe_rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface pe_rr_arbiter_if;

  logic [7:0]  req_hi;
  logic [7:0]  req_lo;
  logic        mode_rr;
  logic        release_i;
  logic        grant_valid;
  logic [7:0]  grant_idx;
  logic [15:0] grant_vec;

  // Requester side drives requests and watches the grant.
  modport master (
    output req_hi, req_lo, mode_rr, release_i,
    input  grant_valid, grant_idx, grant_vec
  );

  // Arbiter side.
  modport slave (
    input  req_hi, req_lo, mode_rr, release_i,
    output grant_valid, grant_idx, grant_vec
  );

endinterface

// File: rtl/pe_masked_pick.sv
// rtl/pe_masked_pick.sv - combinational fixed/round-robin winner selection
module pe_masked_pick
  import pe_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             mode_rr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] mask;
  logic [7:0]       code_masked;
  logic [7:0]       code_all;
  logic [7:0]       code;

  // In RR mode prefer requesters strictly below the last winner, else wrap to the top.
  always_comb begin
    mask        = mode_rr ? ((N_REQ'(1) << last_idx) - N_REQ'(1)) : '0;
    code_masked = pe16(req & mask);
    code_all    = pe16(req);
    code        = (code_masked != NONE_CODE) ? code_masked : code_all;
    found       = (code != NONE_CODE);
    idx         = code[IDX_W-1:0];
  end

endmodule

// File: rtl/pe_rr_arbiter.sv
// rtl/pe_rr_arbiter.sv - 16-requester arbiter with hold limit and registered grant outputs
module pe_rr_arbiter
  import pe_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input logic           clk,
  input logic           rst_n,
  pe_rr_arbiter_if.slave bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic             grant_valid_q;
  logic [7:0]       grant_idx_q;
  logic [N_REQ-1:0] grant_vec_q;

  logic [N_REQ-1:0] req;
  logic             found;
  logic [IDX_W-1:0] pick_idx;
  logic             term;
  logic             do_pick;
  logic             go_idle;

  assign req = {bus.req_hi, bus.req_lo};

  pe_masked_pick u_pick (
    .req      (req),
    .last_idx (last_idx),
    .mode_rr  (bus.mode_rr),
    .found    (found),
    .idx      (pick_idx)
  );

  // While granting, last_idx is the current grantee; decide whether this edge ends the grant.
  always_comb begin
    term    = !req[last_idx] || bus.release_i || (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    do_pick = (state == IDLE) ? found : (term && found);
    go_idle = (state == GRANT) && term && !found;
  end

  // Grant FSM: pick on IDLE requests or on termination, otherwise hold and count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_idx      <= '0;
      hold_cnt      <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= NONE_CODE;
      grant_vec_q   <= '0;
    end else if (do_pick) begin
      state         <= GRANT;
      last_idx      <= pick_idx;
      hold_cnt      <= '0;
      grant_valid_q <= 1'b1;
      grant_idx_q   <= {4'b0000, pick_idx};
      grant_vec_q   <= N_REQ'(1) << pick_idx;
    end else if (go_idle) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= NONE_CODE;
      grant_vec_q   <= '0;
    end else if (state == GRANT) begin
      hold_cnt      <= hold_cnt + 1'b1;
    end
  end

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_vec   = grant_vec_q;

endmodule

// File: doc/pe_rr_arbiter.md
Name: pe_rr_arbiter

Overview:
16-requester arbiter built around the team's 16-bit MSB-first priority-encode function.
- Requests arrive as two 8-bit halves (upper/lower), concatenated as {req_hi, req_lo}.
- A registered FSM selects one grantee in fixed-priority or round-robin mode.
- The grant is held until the grantee is done or the hold limit expires.
- The grant index uses the encoder's existing coding: 0..15, or 0xF0 for none.

Parameters:
- N_REQ, 16, number of requesters. Fixed at 16; not a free parameter.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced re-arbitration. Must be >= 1.
- NONE_CODE, 8'hF0, grant_idx value when no grant is active.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_hi  input  8  request lines for requesters 15..8.
- req_lo  input  8  request lines for requesters 7..0.
- mode_rr  input  1  1 = round-robin, 0 = fixed priority (highest index wins).
- release_i  input  1  single-cycle pulse from the current grantee: done.
- grant_valid  output  1  a grant is active.
- grant_idx  output  8  grantee index zero-extended, or NONE_CODE.
- grant_vec  output  16  one-hot grant, all zero when none.

Behaviour:
Reset:
- Synchronous: rst_n sampled low at a clk edge.
- After that edge: state IDLE, grant_valid 0, grant_idx 0xF0, grant_vec 0, last_idx 0, hold_cnt 0.
- Reset wins over every other event, including mid-grant.

Definitions:
- req = {req_hi, req_lo}.
- Pick function, fixed mode: highest set bit of req.
- Pick function, RR mode: highest set bit strictly below last_idx; if none, highest set bit overall (wrap).
- With last_idx 0 after reset, RR behaves as fixed priority for the first pick.

State IDLE:
- If req != 0: register the pick. After the edge, state GRANT, grant_valid 1, grant_idx/grant_vec show the winner, last_idx = winner, hold_cnt 0.
- Latency: request sampled at edge k, grant visible after edge k.
- If req == 0: stay IDLE.
- release_i is ignored in IDLE.

State GRANT (grantee g):
- Termination occurs when any of the following holds at the edge: req[g] == 0; release_i == 1; hold_cnt == MAX_HOLD-1.
- No termination: hold the grant and increment hold_cnt.
- Termination with req != 0: re-pick at the same edge, with no bubble cycle. Stay in GRANT, hold_cnt 0, last_idx = new winner.
  - The new winner may equal g: sole requester, or fixed mode with g highest.
- Termination with req == 0: go to IDLE with outputs as in reset, but last_idx retained.
- Each grant therefore lasts at most MAX_HOLD cycles.
- MAX_HOLD = 1 re-arbitrates every cycle.

Mode changes:
- mode_rr is sampled only at pick edges; a change mid-grant does not affect the current grant.

Output invariants:
- grant_vec is one-hot iff grant_valid.
- grant_idx[7:4] == 0 whenever grant_valid == 1.
- All outputs are registered (no combinational input-to-output path).

Widths:
- hold_cnt is clog2(MAX_HOLD)+1 bits.
- last_idx is 4 bits.

Decomposition:
Shared package (pe_pkg):
- NONE_CODE
- N_REQ = 16
- IDX_W = 4
- state enum {IDLE, GRANT}
- function pe16 (16-bit MSB-first encode returning 8-bit code or NONE_CODE), reused by the existing encoder.

Sub-module pe_masked_pick (combinational):
- Inputs: req, last_idx, mode_rr. Outputs: found, idx.
- Implementation: mask = bits below last_idx; pick = pe16(req & mask) if nonzero, else pe16(req).

Test Plan:
1. Hold rst_n low 2 cycles with req = 16'hFFFF -> grant_valid 0, grant_idx 0xF0, grant_vec 0. Release reset -> after the next edge, grant_idx 15, grant_vec 16'h8000.
2. Fixed mode, MAX_HOLD 8, req held at 16'h0090 -> grant 7 for exactly 8 cycles, then grant 7 again immediately (no gap). Bit 4 is never granted.
3. RR mode, MAX_HOLD 4, req steady at 16'h8101 -> grant sequence 15, 8, 0, 15, each exactly 4 cycles, no idle cycles between.
4. RR mode, req 16'h0108, grant on 8 -> pulse release_i at hold_cnt 1 -> next cycle grant_idx 3; the following pick wraps to 8.
5. Grant on 5, then req drops to 0 -> next cycle grant_valid 0, grant_idx 0xF0. Reassert req = 16'h0020 -> granted 1 cycle later.
6. Mid-grant (idx 12, hold_cnt 2), assert rst_n low for one edge with req unchanged -> outputs reset. First cycle after reset: grant 12 (pick uses last_idx 0).
